// File: rtl/itof_pipe_if.sv
// Handshake bundle for itof_pipe: operand side (in_valid/in_ready/a) and result side (out_valid/out_ready/c).
// The inexact flag only exists when ITOF_FLAGS_EN is defined.
interface itof_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
`ifdef ITOF_FLAGS_EN
  logic        inexact;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, c, inexact
  );
  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, c, inexact
  );
`else
  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, c
  );
  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, c
  );
`endif
endinterface

// File: rtl/itof_pipe.sv
// Two-stage signed int32 -> binary32 converter, round-to-nearest ties-away-from-zero.
// Optional feature macro ITOF_FLAGS_EN adds the registered inexact flag.
module itof_pipe (
  input  logic        clk,
  input  logic        rstn,
  itof_pipe_if.slave  bus
);

  // Leading-zero count; 32 for an all-zero operand.
  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic       found;
    logic [5:0] cnt;
    found = 1'b0;
    cnt   = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        cnt   = 6'(31 - i);
        found = 1'b1;
      end else begin
        cnt   = cnt;
      end
    end
    return cnt;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q,  s1_sign_d;
  logic [31:0] s1_mag_q,   s1_mag_d;
  logic [5:0]  s1_lz_q,    s1_lz_d;
  logic        s1_zero_q,  s1_zero_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] c_q,        c_d;
`ifdef ITOF_FLAGS_EN
  logic        inexact_q,  inexact_d;
  logic        sticky_s;
`endif

  logic        s2_free_s;
  logic        in_ready_s;
  logic        s1_load_s;
  logic        s2_load_s;
  logic [31:0] a_mag_s;
  logic [23:0] norm_hi_s;
  logic [23:0] m_sum_s;
  logic [7:0]  exp_s;
  logic [31:0] result_s;

  assign s2_free_s  = ~s2_valid_q | bus.out_ready;
  assign in_ready_s = ~s1_valid_q | s2_free_s;
  assign s1_load_s  = bus.in_valid & in_ready_s;
  assign s2_load_s  = s1_valid_q & s2_free_s;

  // Magnitude is computed modulo 2^32, so 0x80000000 maps to 2^31.
  assign a_mag_s = bus.a[31] ? (32'd0 - bus.a) : bus.a;

  // norm_hi_s holds bits [30:7] of the normalized magnitude: 23 mantissa bits plus the round bit.
  assign norm_hi_s = 24'((s1_mag_q << s1_lz_q) >> 7);
  assign m_sum_s   = {1'b0, norm_hi_s[23:1]} + {23'd0, norm_hi_s[0]};
  assign exp_s     = 8'd158 - {2'b00, s1_lz_q};
`ifdef ITOF_FLAGS_EN
  assign sticky_s  = |(7'(s1_mag_q << s1_lz_q));
`endif

  // Stage-2 result assembly: zero, rounding carry into the exponent, or plain rounded value.
  always_comb begin
    result_s = 32'd0;
    if (s1_zero_q) begin
      result_s = 32'd0;
    end else if (m_sum_s[23]) begin
      result_s = {s1_sign_q, exp_s + 8'd1, 23'd0};
    end else begin
      result_s = {s1_sign_q, exp_s, m_sum_s[22:0]};
    end
  end

  // Next-state for both stages: each stage loads when its downstream has room, otherwise holds.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_lz_d    = s1_lz_q;
    s1_zero_d  = s1_zero_q;
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
`ifdef ITOF_FLAGS_EN
    inexact_d  = inexact_q;
`endif
    if (in_ready_s) begin
      s1_valid_d = bus.in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s1_load_s) begin
      s1_sign_d = bus.a[31];
      s1_mag_d  = a_mag_s;
      s1_lz_d   = lzc32(a_mag_s);
      s1_zero_d = (a_mag_s == 32'd0);
    end else begin
      s1_sign_d = s1_sign_q;
    end
    if (s2_free_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s2_load_s) begin
      c_d = result_s;
`ifdef ITOF_FLAGS_EN
      inexact_d = ~s1_zero_q & (norm_hi_s[0] | sticky_s);
`endif
    end else begin
      c_d = c_q;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= 32'd0;
      s1_lz_q    <= 6'd0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      c_q        <= 32'd0;
`ifdef ITOF_FLAGS_EN
      inexact_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s1_lz_q    <= s1_lz_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      c_q        <= c_d;
`ifdef ITOF_FLAGS_EN
      inexact_q  <= inexact_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.c         = c_q;
`ifdef ITOF_FLAGS_EN
  assign bus.inexact   = inexact_q;
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed corner values, stream/stall, async reset, random vectors.
// Expected results come from an arithmetic int->float model and an in-flight queue.
module tb_itof_pipe;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  int   cyc;

  typedef struct {
    logic [31:0] c;
    logic        inx;
    int          acc;
  } exp_t;

  exp_t q[$];

  itof_pipe_if bus ();

  itof_pipe u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {inexact, c} computed from the value of a with division-based rounding.
  function automatic logic [32:0] ref_conv(input logic [31:0] a);
    longint v;
    longint mag;
    longint sig;
    longint p;
    longint rem;
    int     k;
    logic   s;
    logic   inx;
    logic [7:0]  e;
    logic [22:0] m;
    v   = longint'($signed(a));
    s   = (v < 0);
    mag = s ? -v : v;
    if (mag == 0) return 33'd0;
    k = 0;
    while ((mag >> (k + 1)) != 0) k++;
    inx = 1'b0;
    if (k <= 23) begin
      sig = mag << (23 - k);
    end else begin
      p   = longint'(1) << (k - 23);
      sig = mag / p;
      rem = mag % p;
      inx = (rem != 0);
      if (rem * 2 >= p) sig = sig + 1;
      if (sig == (longint'(1) << 24)) begin
        sig = sig / 2;
        k   = k + 1;
      end
    end
    e = 8'(k + 127);
    m = 23'(sig);
    return {inx, s, e, m};
  endfunction

  // One clock cycle: drive, check outputs against the model, update the in-flight queue, advance.
  task automatic cycle(input logic iv, input logic [31:0] ai, input logic ordy,
                       input logic [31:0] ec, input logic ei);
    logic exp_ov;
    logic exp_ir;
    logic took;
    bus.in_valid  = iv;
    bus.a         = ai;
    bus.out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    exp_ir = (q.size() < 2) || ordy;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("c", bus.c, q[0].c);
`ifdef ITOF_FLAGS_EN
      chk("inexact", 32'(bus.inexact), 32'(q[0].inx));
`endif
    end
    took = iv && bus.in_ready;
    if (exp_ov && ordy) void'(q.pop_front());
    if (took) q.push_back('{c: ec, inx: ei, acc: cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle_rand(input logic iv, input logic [31:0] ai, input logic ordy);
    logic [32:0] r;
    r = ref_conv(ai);
    cycle(iv, ai, ordy, r[31:0], r[32]);
  endtask

  function automatic logic [31:0] rand_a();
    logic [31:0] v;
    v = $urandom() >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
    if ($urandom_range(0, 15) == 0) v = 32'h8000_0000;
    return v;
  endfunction

  initial begin
    clk      = 1'b0;
    rstn     = 1'b0;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    bus.in_valid  = 1'b0;
    bus.a         = 32'd0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_c", bus.c, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef ITOF_FLAGS_EN
    chk("rst_inexact", 32'(bus.inexact), 32'd0);
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Directed corner values with constant expectations.
    cycle(1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
    cycle(1'b1, 32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0);
    cycle(1'b1, 32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0);
    cycle(1'b1, 32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 1'b1);
    cycle(1'b1, 32'd16777217,  1'b1, 32'h4B80_0001, 1'b1);
    cycle(1'b1, 32'd16777216,  1'b1, 32'h4B80_0000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 32'd0, 1'b0);

    // Eight back-to-back ops, then a 3-cycle stall with input still offered.
    for (int i = 0; i < 8; i++) cycle_rand(1'b1, rand_a(), 1'b1);
    for (int i = 0; i < 3; i++) cycle_rand(1'b1, rand_a(), 1'b0);
    for (int i = 0; i < 4; i++) cycle_rand(1'b0, 32'd0, 1'b1);

    // Async reset with two ops in flight.
    cycle_rand(1'b1, 32'd12345, 1'b1);
    cycle_rand(1'b1, 32'hFFFF_0000, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_c", bus.c, 32'd0);
`ifdef ITOF_FLAGS_EN
    chk("arst_inexact", 32'(bus.inexact), 32'd0);
`endif
    q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) cycle_rand(1'b0, 32'd0, 1'b1);

    // Random traffic with random valid and back-pressure.
    for (int i = 0; i < 3000; i++) begin
      cycle_rand(($urandom_range(0, 3) != 0), rand_a(), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) cycle_rand(1'b0, 32'd0, 1'b1);
    chk("drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
